// File: rtl/id_decode_pipe.sv
// ARM instruction-decode stage with register file, write-back bypass, condition check,
// RAW/load-use hazard detection and the ID/EXE pipeline register.
module id_decode_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter bit FWD_EN   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction,
  input  logic [3:0]        sr,
  input  logic              wb_en_in,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [3:0]        mem_dest,
  input  logic              mem_wb_en,
  input  logic              freeze,
  input  logic              flush,
  output logic              hazard,
  output logic              two_src,
  output logic              valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic              imm,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] pc,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [4:0] NUM_REGS_5 = 5'(NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [DATA_W-1:0] pc;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
  } id_exe_t;

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, pass;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Addresses outside the file read zero; a same-cycle write to the address wins.
  function automatic logic [DATA_W-1:0] read_reg(input logic [DATA_W-1:0] rf [NUM_REGS],
                                                 input logic [3:0] addr,
                                                 input logic wr_ok,
                                                 input logic [3:0] wr_addr,
                                                 input logic [DATA_W-1:0] wr_data);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      val = (addr == 4'(i)) ? rf[i] : val;
    end
    return (wr_ok && (wr_addr == addr)) ? wr_data : val;
  endfunction

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  id_exe_t           id_exe_r;
  id_exe_t           dec_s;
  logic [3:0]        cond_s, opcode_s, rn_s, rd_s, rm_s, src2_s, cmd_s;
  logic [1:0]        mode_s;
  logic              imm_s, s_bit_s;
  logic              ctl_wb_s, ctl_mr_s, ctl_mw_s, ctl_b_s, ctl_s_s;
  logic              use1_s, exe_match_s, mem_match_s, raw_s, cond_ok_s, wb_ok_s;
  logic [DATA_W-1:0] rd_rn_s, rd_rm_s;

  assign cond_s   = instruction[31:28];
  assign mode_s   = instruction[27:26];
  assign imm_s    = instruction[25];
  assign opcode_s = instruction[24:21];
  assign s_bit_s  = instruction[20];
  assign rn_s     = instruction[19:16];
  assign rd_s     = instruction[15:12];
  assign rm_s     = instruction[3:0];

  // Control decode from mode/opcode/S.
  always_comb begin
    cmd_s    = 4'b0000;
    ctl_wb_s = 1'b0;
    ctl_mr_s = 1'b0;
    ctl_mw_s = 1'b0;
    ctl_b_s  = 1'b0;
    ctl_s_s  = 1'b0;
    case (mode_s)
      2'b00: begin
        case (opcode_s)
          OP_MOV:  begin cmd_s = 4'b0001; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_MVN:  begin cmd_s = 4'b1001; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_ADD:  begin cmd_s = 4'b0010; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_ADC:  begin cmd_s = 4'b0011; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_SUB:  begin cmd_s = 4'b0100; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_SBC:  begin cmd_s = 4'b0101; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_AND:  begin cmd_s = 4'b0110; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_ORR:  begin cmd_s = 4'b0111; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_EOR:  begin cmd_s = 4'b1000; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          OP_CMP:  begin cmd_s = 4'b0100; ctl_s_s = 1'b1; end
          OP_TST:  begin cmd_s = 4'b0110; ctl_s_s = 1'b1; end
          default: cmd_s = 4'b0000;
        endcase
      end
      2'b01: begin
        cmd_s = 4'b0010;
        if (s_bit_s) begin
          ctl_wb_s = 1'b1;
          ctl_mr_s = 1'b1;
        end else begin
          ctl_mw_s = 1'b1;
        end
      end
      2'b10:   ctl_b_s = 1'b1;
      default: cmd_s = 4'b0000;
    endcase
  end

  assign src2_s    = ctl_mw_s ? rd_s : rm_s;
  assign two_src   = ctl_mw_s | ~imm_s;
  assign cond_ok_s = cond_check(cond_s, sr);
  assign wb_ok_s   = wb_en_in && ({1'b0, wb_dest} < NUM_REGS_5);
  assign rd_rn_s   = read_reg(regs_r, rn_s, wb_ok_s, wb_dest, wb_value);
  assign rd_rm_s   = read_reg(regs_r, src2_s, wb_ok_s, wb_dest, wb_value);

  // MOV/MVN and branches ignore rn, so they cannot conflict through src1.
  assign use1_s      = (mode_s != 2'b10) &&
                       !((mode_s == 2'b00) && ((opcode_s == OP_MOV) || (opcode_s == OP_MVN)));
  assign exe_match_s = (use1_s && (rn_s == exe_dest)) || (two_src && (src2_s == exe_dest));
  assign mem_match_s = (use1_s && (rn_s == mem_dest)) || (two_src && (src2_s == mem_dest));
  assign raw_s       = FWD_EN ? (exe_mem_r_en && exe_match_s)
                              : ((exe_wb_en && exe_match_s) || (mem_wb_en && mem_match_s));
  assign hazard      = raw_s && !flush;

  // Decoded ID/EXE payload for the current instruction.
  always_comb begin
    dec_s               = '0;
    dec_s.valid         = 1'b1;
    dec_s.wb_en         = ctl_wb_s;
    dec_s.mem_r_en      = ctl_mr_s;
    dec_s.mem_w_en      = ctl_mw_s;
    dec_s.b             = ctl_b_s;
    dec_s.s             = ctl_s_s;
    dec_s.imm           = imm_s;
    dec_s.exe_cmd       = cmd_s;
    dec_s.val_rn        = rd_rn_s;
    dec_s.val_rm        = rd_rm_s;
    dec_s.pc            = pc_in;
    dec_s.shift_operand = instruction[11:0];
    dec_s.signed_imm_24 = instruction[23:0];
    dec_s.dest          = rd_s;
    dec_s.src1          = rn_s;
    dec_s.src2          = src2_s;
  end

  // Register file write port; independent of freeze and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else if (wb_ok_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_dest == 4'(i)) regs_r[i] <= wb_value;
      end
    end
  end

  // ID/EXE register: freeze holds, flush/hazard/failed condition inject a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_exe_r <= '0;
    end else if (freeze) begin
      id_exe_r <= id_exe_r;
    end else if (flush || hazard || !cond_ok_s) begin
      id_exe_r <= '0;
    end else begin
      id_exe_r <= dec_s;
    end
  end

  assign {valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, val_rn, val_rm, pc,
          shift_operand, signed_imm_24, dest, src1, src2} = id_exe_r;

endmodule
